// File: rtl/btn_pkg.sv
// btn_pkg: shared definitions for the multi-channel button conditioner.
// Holds the per-channel state encoding (debug visibility) and the default
// parameter values used by btn_channel and btn_conditioner.
package btn_pkg;

   // Channel state as seen from the registered hold counter and synchroniser.
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,   // hold counter empty
      ST_ACTIVE = 2'd1,   // button seen pressed, counter loaded
      ST_DECAY  = 2'd2    // button released, counter still running down
   } chan_state_t;

   localparam int DEF_CHANNELS      = 2;
   localparam int DEF_CNT_W         = 4;
   localparam int DEF_HOLD          = 15;
   localparam int DEF_SYNC_STAGES   = 2;
   localparam int DEF_REP_W         = 6;
   localparam int DEF_REPEAT_DELAY  = 40;
   localparam int DEF_REPEAT_PERIOD = 10;

   // Classify a channel: an empty counter is IDLE even while the press is
   // still propagating into it; otherwise the synchronised input decides.
   function automatic chan_state_t chan_state(input logic s, input logic cnt_nz);
      if (!cnt_nz) begin
         return ST_IDLE;
      end else if (s) begin
         return ST_ACTIVE;
      end else begin
         return ST_DECAY;
      end
   endfunction

endpackage

// File: rtl/btn_channel.sv
// btn_channel: one button channel -- input synchroniser, tick-driven hold
// counter that stretches the press, and press/release edge strobes.
// Optional auto-repeat strobes on press when BTN_REPEAT_EN is defined.
module btn_channel
   import btn_pkg::*;
#(
   parameter int CNT_W         = DEF_CNT_W,
   parameter int HOLD          = DEF_HOLD,
   parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
   parameter int REP_W         = DEF_REP_W,
   parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
   parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_tick,
   input  logic i_button,
   output logic o_level,
   output logic o_press,
   output logic o_release
);

   localparam logic [CNT_W-1:0] HOLD_V = CNT_W'(HOLD);

   // Elaboration-time parameter sanity checks.
   generate
      if (HOLD < 1 || HOLD > (2 ** CNT_W) - 1) begin : g_bad_hold
         $error("btn_channel: HOLD must be in 1..2^CNT_W-1");
      end
      if (SYNC_STAGES < 0 || SYNC_STAGES > 3) begin : g_bad_sync
         $error("btn_channel: SYNC_STAGES must be in 0..3");
      end
      if (REPEAT_PERIOD < 1 || REPEAT_PERIOD > REPEAT_DELAY ||
          REPEAT_DELAY >= (2 ** REP_W)) begin : g_bad_rep
         $error("btn_channel: need 1 <= REPEAT_PERIOD <= REPEAT_DELAY < 2^REP_W");
      end
   endgenerate

   logic             w_s;
   logic [CNT_W-1:0] r_cnt;
   logic             r_lvl_q;
   logic             w_level;
   logic             w_rep_hit;
   chan_state_t      w_state;

   generate
      if (SYNC_STAGES == 0) begin : g_nosync
         assign w_s = i_button;
      end else begin : g_sync
         logic [SYNC_STAGES-1:0] r_sync;
         // Shift the asynchronous pad level through the synchroniser chain.
         always_ff @(posedge i_clk) begin
            if (!i_rst_n) begin
               r_sync <= '0;
            end else begin
               r_sync <= (r_sync << 1) | SYNC_STAGES'(i_button);
            end
         end
         assign w_s = r_sync[SYNC_STAGES-1];
      end
   endgenerate

   // Reload while pressed (wins over tick); otherwise count down per tick.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_cnt <= '0;
      end else if (w_s) begin
         r_cnt <= HOLD_V;
      end else if (i_tick && (r_cnt != '0)) begin
         r_cnt <= r_cnt - CNT_W'(1);
      end
   end

   assign w_state = chan_state(w_s, r_cnt != '0);
   assign w_level = (w_state != ST_IDLE);

   // Keep last cycle's level so edges can be detected.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_lvl_q <= 1'b0;
      end else begin
         r_lvl_q <= w_level;
      end
   end

`ifdef BTN_REPEAT_EN
   localparam logic [REP_W-1:0] REP_DELAY_V  = REP_W'(REPEAT_DELAY);
   localparam logic [REP_W-1:0] REP_RELOAD_V = REP_W'(REPEAT_DELAY - REPEAT_PERIOD);

   logic [REP_W-1:0] r_rep;
   logic [REP_W-1:0] w_rep_inc;

   assign w_rep_inc = r_rep + REP_W'(1);
   // A repeat fires in the cycle whose tick would carry rep onto the delay.
   assign w_rep_hit = w_s & i_tick & (w_rep_inc == REP_DELAY_V);

   // Count ticks of continuous hold; fold back by one period after each repeat.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_rep <= '0;
      end else if (!w_s) begin
         r_rep <= '0;
      end else if (i_tick) begin
         r_rep <= w_rep_hit ? REP_RELOAD_V : w_rep_inc;
      end
   end
`else
   assign w_rep_hit = 1'b0;
`endif

   assign o_level   = w_level;
   assign o_press   = (w_level & ~r_lvl_q) | w_rep_hit;
   assign o_release = ~w_level & r_lvl_q;

endmodule

// File: rtl/btn_conditioner.sv
// btn_conditioner: N independent button channels sharing one tick strobe.
// Each channel synchronises, stretches and edge-detects its raw pad input.
// Define BTN_REPEAT_EN to add auto-repeat strobes on o_press.
module btn_conditioner
   import btn_pkg::*;
#(
   parameter int CHANNELS      = DEF_CHANNELS,
   parameter int CNT_W         = DEF_CNT_W,
   parameter int HOLD          = DEF_HOLD,
   parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
   parameter int REP_W         = DEF_REP_W,
   parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
   parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
   input  logic                i_clk,
   input  logic                i_rst_n,
   input  logic                i_tick,
   input  logic [CHANNELS-1:0] i_button_in,
   output logic [CHANNELS-1:0] o_level,
   output logic [CHANNELS-1:0] o_press,
   output logic [CHANNELS-1:0] o_release
);

   generate
      if (CHANNELS < 1 || CHANNELS > 8) begin : g_bad_channels
         $error("btn_conditioner: CHANNELS must be in 1..8");
      end

      for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
         btn_channel #(
            .CNT_W         (CNT_W),
            .HOLD          (HOLD),
            .SYNC_STAGES   (SYNC_STAGES),
            .REP_W         (REP_W),
            .REPEAT_DELAY  (REPEAT_DELAY),
            .REPEAT_PERIOD (REPEAT_PERIOD)
         ) u_ch (
            .i_clk     (i_clk),
            .i_rst_n   (i_rst_n),
            .i_tick    (i_tick),
            .i_button  (i_button_in[g]),
            .o_level   (o_level[g]),
            .o_press   (o_press[g]),
            .o_release (o_release[g])
         );
      end
   endgenerate

endmodule

// File: tb/tb_btn_conditioner.sv
// tb_btn_conditioner: self-checking bench for btn_conditioner.
// Expected strobe events are queued as stimulus is driven; a negedge monitor
// logs the strobes the DUT produces, and each test compares the two queues.
module tb_btn_conditioner;

   localparam int CH         = 2;
   localparam int HOLD       = 15;
   localparam int REP_DELAY  = 40;
   localparam int REP_PERIOD = 10;

   typedef struct packed {
      int   cyc;
      int   ch;
      logic rel;
   } ev_t;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          tick;
   logic [CH-1:0] button_in;
   logic [CH-1:0] o_level;
   logic [CH-1:0] o_press;
   logic [CH-1:0] o_release;

   int  cyc = 0;
   int  n_cmp = 0;
   int  n_fail = 0;
   ev_t exp_q[$];
   ev_t obs_q[$];

   btn_conditioner #(
      .CHANNELS      (CH),
      .CNT_W         (4),
      .HOLD          (HOLD),
      .SYNC_STAGES   (2),
      .REP_W         (6),
      .REPEAT_DELAY  (REP_DELAY),
      .REPEAT_PERIOD (REP_PERIOD)
   ) dut (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_tick      (tick),
      .i_button_in (button_in),
      .o_level     (o_level),
      .o_press     (o_press),
      .o_release   (o_release)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Log every strobe with the cycle (edge count) in which it is visible.
   always @(negedge clk) begin
      for (int c = 0; c < CH; c++) begin
         if (o_press[c] === 1'b1)   obs_q.push_back(ev_t'{cyc, c, 1'b0});
         if (o_release[c] === 1'b1) obs_q.push_back(ev_t'{cyc, c, 1'b1});
      end
   end

   task automatic apply_reset();
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         rst_n = (i >= 2);
         tick = 1'b0;
         button_in = '0;
      end
      @(negedge clk); #1;
      exp_q.delete();
      obs_q.delete();
   endtask

   task automatic test_reset();
      int e0;
      logic exp_lvl;
      ev_t e, o;
      exp_q.delete();
      obs_q.delete();
      for (int i = 0; i < 16; i++) begin
         @(posedge clk); #1;
         if (i == 0) begin
            e0 = cyc;
            exp_q.push_back(ev_t'{e0 + 6, 0, 1'b0});
         end
         rst_n = !(i < 3 || i == 10 || i == 11);
         tick = 1'b0;
         button_in = {1'b0, (i < 10)};
         @(negedge clk);
         if (i >= 1) begin
            exp_lvl = (i >= 6 && i <= 10);
            n_cmp++;
            if (o_level !== {1'b0, exp_lvl}) begin
               n_fail++;
               $display("FAIL reset_level: step %0d level %b, want %b", i, o_level, {1'b0, exp_lvl});
            end
            if (i <= 5) begin
               n_cmp++;
               if ({o_press, o_release} !== 4'b0000) begin
                  n_fail++;
                  $display("FAIL reset_strobes: step %0d press %b release %b, want 00 00", i, o_press, o_release);
               end
            end
         end
      end
      #1;
      n_cmp++;
      if (obs_q.size() != exp_q.size()) begin
         n_fail++;
         $display("FAIL reset_evcount: got %0d events, want %0d", obs_q.size(), exp_q.size());
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         n_cmp++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL reset_event: got cyc %0d ch %0d rel %b, want cyc %0d ch %0d rel %b", o.cyc, o.ch, o.rel, e.cyc, e.ch, e.rel);
         end
      end
      exp_q.delete();
      obs_q.delete();
   endtask

   task automatic test_hold_release();
      int e0, erel, ntk;
      logic exp_lvl;
      ev_t e, o;
      apply_reset();
      erel = 0;
      for (int i = 0; i < 90; i++) begin
         @(posedge clk); #1;
         if (i == 0) begin
            e0 = cyc;
            ntk = 0;
            // Button drops at drive e0+10; counting edges start at e0+13.
            for (int k = e0 + 13; erel == 0; k++) begin
               if (k % 4 == 0) ntk++;
               if (ntk == HOLD) erel = k;
            end
            exp_q.push_back(ev_t'{e0 + 3, 0, 1'b0});
            exp_q.push_back(ev_t'{erel, 0, 1'b1});
         end
         tick = ((cyc + 1) % 4 == 0);
         button_in = {1'b0, (i < 10)};
         @(negedge clk);
         exp_lvl = (cyc >= e0 + 3) && (cyc < erel);
         n_cmp++;
         if (o_level !== {1'b0, exp_lvl}) begin
            n_fail++;
            $display("FAIL hold_level: cycle %0d level %b, want %b", cyc - e0, o_level, {1'b0, exp_lvl});
         end
      end
      #1;
      n_cmp++;
      if (obs_q.size() != exp_q.size()) begin
         n_fail++;
         $display("FAIL hold_evcount: got %0d events, want %0d", obs_q.size(), exp_q.size());
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         n_cmp++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL hold_event: got cyc %0d ch %0d rel %b, want cyc %0d ch %0d rel %b", o.cyc, o.ch, o.rel, e.cyc, e.ch, e.rel);
         end
      end
      exp_q.delete();
      obs_q.delete();
   endtask

   task automatic test_bounce();
      int e0;
      logic [CH-1:0] exp_lvl;
      ev_t e, o;
      apply_reset();
      for (int i = 0; i < 45; i++) begin
         @(posedge clk); #1;
         if (i == 0) begin
            e0 = cyc;
            exp_q.push_back(ev_t'{e0 + 3, 1, 1'b0});
            exp_q.push_back(ev_t'{e0 + 19 + HOLD + 2, 1, 1'b1});
         end
         tick = 1'b1;
         button_in = {(i < 20) && (i % 2 == 0), 1'b0};
         @(negedge clk);
         exp_lvl = {(cyc >= e0 + 3) && (cyc < e0 + 19 + HOLD + 2), 1'b0};
         n_cmp++;
         if (o_level !== exp_lvl) begin
            n_fail++;
            $display("FAIL bounce_level: cycle %0d level %b, want %b", cyc - e0, o_level, exp_lvl);
         end
      end
      #1;
      n_cmp++;
      if (obs_q.size() != exp_q.size()) begin
         n_fail++;
         $display("FAIL bounce_evcount: got %0d events, want %0d", obs_q.size(), exp_q.size());
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         n_cmp++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL bounce_event: got cyc %0d ch %0d rel %b, want cyc %0d ch %0d rel %b", o.cyc, o.ch, o.rel, e.cyc, e.ch, e.rel);
         end
      end
      exp_q.delete();
      obs_q.delete();
   endtask

   task automatic test_independence();
      int e0;
      logic [CH-1:0] exp_lvl;
      ev_t e, o;
      apply_reset();
      for (int i = 0; i < 35; i++) begin
         @(posedge clk); #1;
         if (i == 0) begin
            e0 = cyc;
            exp_q.push_back(ev_t'{e0 + 3, 0, 1'b0});
            exp_q.push_back(ev_t'{e0 + 6, 1, 1'b0});
            exp_q.push_back(ev_t'{e0 + 6 + HOLD + 2, 0, 1'b1});
            exp_q.push_back(ev_t'{e0 + 11 + HOLD + 2, 1, 1'b1});
         end
         tick = 1'b1;
         button_in = {(i >= 3 && i < 11), (i < 6)};
         @(negedge clk);
         exp_lvl = {(cyc >= e0 + 6) && (cyc < e0 + 11 + HOLD + 2),
                    (cyc >= e0 + 3) && (cyc < e0 + 6 + HOLD + 2)};
         n_cmp++;
         if (o_level !== exp_lvl) begin
            n_fail++;
            $display("FAIL indep_level: cycle %0d level %b, want %b", cyc - e0, o_level, exp_lvl);
         end
      end
      #1;
      n_cmp++;
      if (obs_q.size() != exp_q.size()) begin
         n_fail++;
         $display("FAIL indep_evcount: got %0d events, want %0d", obs_q.size(), exp_q.size());
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         n_cmp++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL indep_event: got cyc %0d ch %0d rel %b, want cyc %0d ch %0d rel %b", o.cyc, o.ch, o.rel, e.cyc, e.ch, e.rel);
         end
      end
      exp_q.delete();
      obs_q.delete();
   endtask

   task automatic test_back_to_back();
      int e0;
      logic [CH-1:0] exp_lvl;
      ev_t e, o;
      apply_reset();
      for (int i = 0; i < 35; i++) begin
         @(posedge clk); #1;
         if (i == 0) begin
            e0 = cyc;
            exp_q.push_back(ev_t'{e0 + 3, 0, 1'b0});
            exp_q.push_back(ev_t'{e0 + 11 + HOLD + 2, 0, 1'b1});
         end
         tick = 1'b1;
         button_in = {1'b0, (i < 3) || (i >= 8 && i < 11)};
         @(negedge clk);
         exp_lvl = {1'b0, (cyc >= e0 + 3) && (cyc < e0 + 11 + HOLD + 2)};
         n_cmp++;
         if (o_level !== exp_lvl) begin
            n_fail++;
            $display("FAIL repress_level: cycle %0d level %b, want %b", cyc - e0, o_level, exp_lvl);
         end
      end
      #1;
      n_cmp++;
      if (obs_q.size() != exp_q.size()) begin
         n_fail++;
         $display("FAIL repress_evcount: got %0d events, want %0d", obs_q.size(), exp_q.size());
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         n_cmp++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL repress_event: got cyc %0d ch %0d rel %b, want cyc %0d ch %0d rel %b", o.cyc, o.ch, o.rel, e.cyc, e.ch, e.rel);
         end
      end
      exp_q.delete();
      obs_q.delete();
   endtask

   task automatic test_repeat();
      int e0;
      logic [CH-1:0] exp_lvl;
      ev_t e, o;
      apply_reset();
      for (int i = 0; i < 100; i++) begin
         @(posedge clk); #1;
         if (i == 0) begin
            e0 = cyc;
            exp_q.push_back(ev_t'{e0 + 3, 0, 1'b0});
`ifdef BTN_REPEAT_EN
            for (int r = 0; r < 4; r++) begin
               exp_q.push_back(ev_t'{e0 + REP_DELAY + 1 + REP_PERIOD * r, 0, 1'b0});
            end
`endif
            exp_q.push_back(ev_t'{e0 + 75 + HOLD + 2, 0, 1'b1});
         end
         tick = 1'b1;
         button_in = {1'b0, (i < 75)};
         @(negedge clk);
         exp_lvl = {1'b0, (cyc >= e0 + 3) && (cyc < e0 + 75 + HOLD + 2)};
         n_cmp++;
         if (o_level !== exp_lvl) begin
            n_fail++;
            $display("FAIL repeat_level: cycle %0d level %b, want %b", cyc - e0, o_level, exp_lvl);
         end
      end
      #1;
      n_cmp++;
      if (obs_q.size() != exp_q.size()) begin
         n_fail++;
         $display("FAIL repeat_evcount: got %0d events, want %0d", obs_q.size(), exp_q.size());
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         n_cmp++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL repeat_event: got cyc %0d ch %0d rel %b, want cyc %0d ch %0d rel %b", o.cyc, o.ch, o.rel, e.cyc, e.ch, e.rel);
         end
      end
      exp_q.delete();
      obs_q.delete();
   endtask

   initial begin
      rst_n = 1'b0;
      tick = 1'b0;
      button_in = '0;
      test_reset();
      test_hold_release();
      test_bounce();
      test_independence();
      test_back_to_back();
      test_repeat();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/btn_conditioner.md
# btn_conditioner

Multi-channel button conditioner for the game's user inputs (jump, duck, start). Each channel synchronises a raw pad input, stretches it with a tick-driven hold counter, and produces a clean level plus single-cycle press and release strobes. It sits between the input pads and the game FSM and generalises the single-channel stretch debouncer to N channels. It adds configurable synchronisation depth, edge strobes, and optional auto-repeat.

## Interface
Parameters:
- `CHANNELS`, default 2: number of independent button channels (1..8).
- `CNT_W`, default 4: hold-counter width per channel.
- `HOLD`, default 15: reload value of the hold counter; constraint 1 ≤ HOLD ≤ 2^CNT_W−1.
- `SYNC_STAGES`, default 2: input synchroniser flops (0..3); 0 means a direct combinational path.
- `REP_W`, default 6: auto-repeat counter width (used only with `BTN_REPEAT_EN`).
- `REPEAT_DELAY`, default 40: ticks of continuous hold before the first repeat strobe.
- `REPEAT_PERIOD`, default 10: ticks between subsequent repeat strobes; constraint 1 ≤ PERIOD ≤ DELAY < 2^REP_W.

Ports:
- `clk` in 1: sole clock.
- `rst_n` in 1: synchronous, active-low reset; sampled on the rising edge of `clk`.
- `tick` in 1: countdown enable, one-cycle strobe from the frame/timebase divider.
- `button_in` in CHANNELS: raw, asynchronous button inputs, active-high.
- `level` out CHANNELS: debounced/stretched level.
- `press` out CHANNELS: one-cycle strobe on press; also carries repeat strobes when `BTN_REPEAT_EN` is defined.
- `release` out CHANNELS: one-cycle strobe on release.

## Operation
Channels are fully independent; each behaves as follows.
- **Synchroniser:** `button_in[i]` passes through SYNC_STAGES flops to give `s[i]`. The flops reset to 0.
- **Hold counter `cnt`:**
  - If `s` = 1, `cnt` ← HOLD.
  - Otherwise, if `tick` is high and `cnt` ≠ 0, `cnt` ← `cnt` − 1.
  - Otherwise `cnt` holds.
  - When `s` = 1 and `tick` arrive in the same cycle, the reload wins.
- **Outputs:**
  - `level` = (`cnt` ≠ 0).
  - `lvl_q` is a registered copy of `level`.
  - `press` = `level` & ~`lvl_q`.
  - `release` = ~`level` & `lvl_q`.
- **Channel states:**
  - IDLE (`cnt` = 0), moves to ACTIVE when `s` = 1.
  - ACTIVE (`s` = 1), moves to DECAY when `s` = 0.
  - DECAY (`s` = 0, `cnt` > 0), moves back to ACTIVE on re-press and counts down to IDLE on ticks.
- A re-press during DECAY produces no new `press` strobe and no `release` strobe.
- Reset values: `cnt`, `lvl_q`, the synchronisers and the repeat counters are all 0. Consequently `level`, `press` and `release` are 0 during reset and in the first cycle after reset.
- If a button is held through reset, `press` fires normally once `s` propagates after reset is released.
- Reset in mid-operation clears all state immediately, with no `release` strobe.

## Timing
The figures below assume SYNC_STAGES = 2.
- `button_in` rises before edge k.
- `s` is high after edge k+1.
- `cnt` = HOLD after edge k+2.
- `level` and `press` are high in the cycle after edge k+2; `press` lasts exactly one cycle.
- Press latency is SYNC_STAGES+1 cycles.
- Release: `level` falls in the cycle after the edge on which `cnt` reaches 0 (HOLD ticks after `s` falls). `release` is high for that single cycle.
- With `tick` held constantly high, release latency after `s` falls is HOLD cycles.

## Configuration
Macro: `BTN_REPEAT_EN`.
- **Defined:** each channel has a REP_W-bit counter `rep`.
  - `rep` is cleared whenever `s` = 0.
  - While `s` = 1, each `tick` increments `rep`.
  - When the increment would make `rep` equal REPEAT_DELAY, `press` pulses in that cycle and `rep` ← DELAY − PERIOD. This gives strobes at DELAY, DELAY+PERIOD, and so on.
  - A repeat strobe coincident with the initial press edge is merged into a single `press` cycle.
- **Undefined:** no `rep` logic and no repeat strobes. The REP_W, REPEAT_DELAY and REPEAT_PERIOD parameters are accepted and ignored.

## Structure
- Package `btn_pkg` holds the channel-state encoding constants (IDLE/ACTIVE/DECAY, for debug visibility) and default parameter values.
- Sub-module `btn_channel` holds one channel (synchroniser, `cnt`, `lvl_q`, optional `rep`).
- The top level instantiates `btn_channel` CHANNELS times via a generate loop, sharing `tick`.

## Test plan
- **Reset with button held:** `rst_n` = 0 for 3 cycles while `button_in` = 01.
  - Outputs must be 0 during reset.
  - `press[0]` must pulse exactly once, 3 cycles after `rst_n` rises.
- **Hold release timing:** HOLD = 15, tick every 4th cycle, press for 10 cycles then release.
  - `level` must stay high until exactly 15 ticks after `s` falls.
  - `release` must be a one-cycle pulse; exactly one `press` overall.
- **Bounce:** toggle `button_in[1]` 1/0 every cycle for 20 cycles.
  - `level[1]` must stay high continuously, with a single `press` and a single `release` at the end.
- **Channel independence and reload priority:** channels 0 and 1 pressed in staggered fashion, with `tick` coincident with `s` rising.
  - Reload must win, giving `cnt` = HOLD.
  - Neither channel's strobes may affect the other.
- **Auto-repeat (`BTN_REPEAT_EN`):** DELAY = 40, PERIOD = 10, tick every cycle, hold for 75 cycles.
  - `press` pulses at the initial edge and at ticks 40, 50, 60 and 70.
  - No pulses after release.
  - With the macro undefined, only the initial pulse occurs.
